// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// traffic_light_ctrl: two-road timed light controller with pedestrian
// request, run/hold enable and flashing-fault mode.   Revision 1.0
// ============================================================================
module traffic_light_ctrl #(
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int RED_TICKS    = 2,
  parameter int MIN_GREEN    = 3,
  parameter int FLASH_TICKS  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       flash_mode,
  input  logic       ped_req,
  output logic [0:2] light_main,
  output logic [0:2] light_side,
  output logic       ped_walk,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    ALL_R2 = 3'd5,
    FLASH  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_TICKS - 1);

  localparam logic [0:2] LAMP_RED    = 3'b100;
  localparam logic [0:2] LAMP_GREEN  = 3'b010;
  localparam logic [0:2] LAMP_YELLOW = 3'b001;
  localparam logic [0:2] LAMP_DARK   = 3'b000;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             blink, blink_nx;
  logic             ped_pend, ped_pend_nx;
  logic             walk_r, walk_nx;
  logic [CNT_W-1:0] phase_last;
  logic             phase_done;
  logic             entering_side;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ALL_R2;
      cnt      <= '0;
      blink    <= 1'b1;
      ped_pend <= 1'b0;
      walk_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      blink    <= blink_nx;
      ped_pend <= ped_pend_nx;
      walk_r   <= walk_nx;
    end
  end

  always_comb begin
    phase_last = RED_LAST;
    case (state)
      MAIN_G, SIDE_G: phase_last = GREEN_LAST;
      MAIN_Y, SIDE_Y: phase_last = YELLOW_LAST;
      default:        phase_last = RED_LAST;
    endcase
    // A pending pedestrian may cut main green once the minimum has elapsed.
    phase_done = enable &&
                 ((cnt == phase_last) ||
                  (state == MAIN_G && ped_pend && cnt >= MIN_LAST));
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    blink_nx = blink;
    if (state != FLASH && flash_mode) begin
      state_nx = FLASH;
      cnt_nx   = '0;
      blink_nx = 1'b1;
    end else if (state == FLASH) begin
      if (!flash_mode) begin
        state_nx = ALL_R2;
        cnt_nx   = '0;
      end else if (cnt == FLASH_LAST) begin
        blink_nx = ~blink;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end else if (state == state_t'(3'd7)) begin
      state_nx = ALL_R2;
      cnt_nx   = '0;
    end else if (phase_done) begin
      cnt_nx = '0;
      case (state)
        MAIN_G:  state_nx = MAIN_Y;
        MAIN_Y:  state_nx = ALL_R1;
        ALL_R1:  state_nx = SIDE_G;
        SIDE_G:  state_nx = SIDE_Y;
        SIDE_Y:  state_nx = ALL_R2;
        ALL_R2:  state_nx = MAIN_G;
        default: state_nx = ALL_R2;
      endcase
    end else if (enable) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  always_comb begin
    entering_side = (state_nx == SIDE_G) && (state != SIDE_G);
    ped_pend_nx   = ped_req | (ped_pend & ~entering_side);
    walk_nx       = walk_r;
    if (entering_side) begin
      walk_nx = ped_pend;
    end else if (state == SIDE_G && state_nx != SIDE_G) begin
      walk_nx = 1'b0;
    end
  end

  always_comb begin
    light_main = LAMP_RED;
    light_side = LAMP_RED;
    case (state)
      MAIN_G: light_main = LAMP_GREEN;
      MAIN_Y: light_main = LAMP_YELLOW;
      SIDE_G: light_side = LAMP_GREEN;
      SIDE_Y: light_side = LAMP_YELLOW;
      FLASH: begin
        light_main = blink ? LAMP_YELLOW : LAMP_DARK;
        light_side = blink ? LAMP_RED    : LAMP_DARK;
      end
      default: begin
        light_main = LAMP_RED;
        light_side = LAMP_RED;
      end
    endcase
  end

  assign ped_walk = (state == SIDE_G) && walk_r;
  assign state_o  = state;

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-road traffic-light controller, the successor to the single-lamp red/green/yellow cycler. Drives a main road and a side road through timed green/yellow/all-red phases with per-phase dwell parameters. Adds a pedestrian request that can shorten main green, a run/hold enable, and a flashing-fault mode. Sits directly under the intersection top level and is clocked by the system clock.

## Interface
- `CNT_W`, 8: phase timer width. Every duration parameter must be ≤ 2^CNT_W.
- `GREEN_TICKS`, 8: green dwell in enabled cycles, both roads.
- `YELLOW_TICKS`, 3: yellow dwell.
- `RED_TICKS`, 2: all-red clearance dwell.
- `MIN_GREEN`, 3: minimum main-green cycles before a pedestrian request may cut it short. Must satisfy 1 ≤ MIN_GREEN ≤ GREEN_TICKS.
- `FLASH_TICKS`, 4: half-period of the flash blink.
- `clock`, input, 1: rising-edge system clock.
- `reset_n`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: high lets the phase timer run; low freezes state and timer.
- `flash_mode`, input, 1: high selects flashing-fault mode.
- `ped_req`, input, 1: pedestrian request. A single-cycle pulse is sufficient.
- `light_main`, output, [0:2]: main-road lamp. Red=100, green=010, yellow=001, dark=000.
- `light_side`, output, [0:2]: side-road lamp, same encoding.
- `ped_walk`, output, 1: walk signal.
- `state_o`, output, 3: current state code.

## Operation
- **States and codes:** MAIN_G=0, MAIN_Y=1, ALL_R1=2, SIDE_G=3, SIDE_Y=4, ALL_R2=5, FLASH=6. Code 7 is illegal and recovers to ALL_R2 with cnt=0.
- **Normal cycle:** MAIN_G→MAIN_Y→ALL_R1→SIDE_G→SIDE_Y→ALL_R2→MAIN_G.
- **Lamp decode:**
  - MAIN_G: main=010, side=100.
  - MAIN_Y: main=001, side=100.
  - SIDE_G: main=100, side=010.
  - SIDE_Y: main=100, side=001.
  - ALL_R1 and ALL_R2: both 100.
  - FLASH: main=001 and side=100 when `blink`=1; both 000 when `blink`=0.
- **Timer `cnt`:**
  - `cnt` is an up-counter, cleared to 0 on every state change.
  - When `enable`=1 and the phase is not done, it increments by 1.
  - A phase of duration D is done when `cnt`==D-1 and `enable`=1. The state then advances at that edge.
- **Pedestrian latch `ped_pend`:**
  - Next value = `ped_req` | (`ped_pend` & ~entering SIDE_G).
  - A request arriving in the same cycle as SIDE_G entry therefore stays pending for the next round.
- **Early exit from MAIN_G:** MAIN_G also exits when `enable`=1, `ped_pend`=1 and `cnt` ≥ MIN_GREEN-1.
- **Walk flag:**
  - `walk_r` is loaded with `ped_pend` on SIDE_G entry and cleared on SIDE_G exit.
  - `ped_walk` = `walk_r` while in SIDE_G, otherwise 0.
- **Enable low:** `cnt` and state hold. `ped_req` is still latched. Flash entry and exit are still honoured.
- **Flash mode:**
  - `flash_mode`=1 in any non-FLASH state: next edge enters FLASH, with `cnt`=0 and `blink`=1. This ignores `enable`.
  - In FLASH, `cnt` counts every cycle regardless of `enable`.
  - At `cnt`==FLASH_TICKS-1, `blink` toggles and `cnt` clears.
  - `flash_mode`=0 while in FLASH: next edge goes to ALL_R2 with `cnt`=0.
  - `ped_pend` is held during FLASH. `ped_walk` is 0 in FLASH.
- **Priority, highest first:** reset, flash entry/exit, phase advance, count.

## Timing
- **Reset:** `reset_n`=0 at a rising edge sets state=ALL_R2, `cnt`=0, `ped_pend`=0, `walk_r`=0, `blink`=1. This applies mid-phase and in FLASH.
- **Output values during reset:** `light_main`=100, `light_side`=100, `ped_walk`=0, `state_o`=5.
- **Output latency:** all outputs are a combinational decode of registered state. Lamps change in the same cycle as `state_o`, with no extra latency.
- **Enabled dwell:** each phase lasts exactly its parameter in cycles with `enable`=1. Cycles with `enable`=0 add to the dwell 1:1.
- **Default enabled period:** 8+3+2+8+3+2 = 26 cycles.
- **Reset release:** the first MAIN_G starts RED_TICKS=2 enabled cycles after the first enabled cycle following reset release.
- **Flash blink:** default period is 2·FLASH_TICKS = 8 cycles.

## Test plan
- **Reset and free run:** reset 3 cycles, then `enable`=1 with defaults → `state_o` 5,5,0×8,1×3,2×2,3×8,4×3,5×2, repeating with period 26. Lamp codes match the decode every cycle. `ped_walk` stays 0.
- **Pedestrian cut:** `ped_req` pulse in MAIN_G at `cnt`=0 → MAIN_G lasts 3 cycles, then MAIN_Y. `ped_walk`=1 for all 8 SIDE_G cycles, then 0. The following round has a full 8-cycle MAIN_G.
- **Late request:** `ped_req` in the SIDE_G entry cycle → no walk that round. The next MAIN_G is cut to 3 cycles and the next SIDE_G shows walk.
- **Enable hold:** drop `enable` for 5 cycles at MAIN_Y `cnt`=1 → state and `cnt` frozen. MAIN_Y totals 8 wall-clock cycles.
- **Flash:** raise `flash_mode` in SIDE_G → next cycle `state_o`=6, `light_main` alternates 001/000 and `light_side` 100/000 every 4 cycles. Lower it → next cycle ALL_R2 for 2 cycles, then MAIN_G.
- **Reset mid-operation:** assert `reset_n`=0 for 1 cycle in SIDE_G with `ped_pend`=1 → next cycle state 5, both lamps 100, `ped_pend` cleared, and no walk in the following SIDE_G.
